// File: rtl/fsm_counter_cmd_decoder.sv
// Recovers the w1w0 command behind each step of an up/down counter by watching its sampled state.
// Optional build macro RESET_INFER_EN: an illegal step landing on 0 is read as a counter reset (ResetSeen pulse).
module fsm_counter_cmd_decoder #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Sample,
  input  logic [WIDTH-1:0] Count,
  output logic             CmdValid,
  output logic             w1,
  output logic             w0,
  output logic             Locked,
  output logic             Illegal,
  output logic             Fault,
  output logic [7:0]       DecodeCount
`ifdef RESET_INFER_EN
  ,
  output logic             ResetSeen
`endif
);

  typedef enum logic [1:0] {
    S_UNSYNC = 2'd0,
    S_TRACK  = 2'd1,
    S_FAULT  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [3:0]       err_run_q;
  logic             cmd_valid_q;
  logic             illegal_q;
  logic [1:0]       code_q;
  logic [7:0]       dcount_q;

  logic [WIDTH-1:0] delta;
  logic             step_legal;
  logic [1:0]       step_code;
  logic [4:0]       err_run_d;

  // Step size is taken modulo 2^WIDTH so that wrap-around decodes like any other step.
  always_comb begin
    delta      = Count - prev_q;
    step_legal = 1'b1;
    step_code  = 2'b00;
    err_run_d  = {1'b0, err_run_q} + 5'd1;
    if (delta == '0) begin
      step_code = 2'b00;
    end else if (delta == WIDTH'(1)) begin
      step_code = 2'b01;
    end else if (delta == WIDTH'(2)) begin
      step_code = 2'b10;
    end else if (delta == '1) begin
      step_code = 2'b11;
    end else begin
      step_legal = 1'b0;
    end
  end

`ifdef RESET_INFER_EN
  logic reset_seen_q;
  assign ResetSeen = reset_seen_q;
`endif

  // NOTE: state and outputs share one clocked block; every assignment here is non-blocking so
  // all registers see the pre-edge values of each other regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_UNSYNC;
      prev_q      <= '0;
      err_run_q   <= '0;
      cmd_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      code_q      <= 2'b00;
      dcount_q    <= 8'd0;
`ifdef RESET_INFER_EN
      reset_seen_q <= 1'b0;
`endif
    end else begin
      cmd_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef RESET_INFER_EN
      reset_seen_q <= 1'b0;
`endif
      unique case (state_q)
        S_UNSYNC: begin
          if (Sample) begin
            prev_q  <= Count;
            state_q <= S_TRACK;
          end
        end
        S_TRACK: begin
          if (Sample) begin
            prev_q <= Count;
            if (step_legal) begin
              cmd_valid_q <= 1'b1;
              code_q      <= step_code;
              err_run_q   <= '0;
              if (dcount_q != 8'hFF) dcount_q <= dcount_q + 8'd1;
            end
`ifdef RESET_INFER_EN
            else if (Count == '0) begin
              err_run_q    <= '0;
              reset_seen_q <= 1'b1;
            end
`endif
            else begin
              illegal_q <= 1'b1;
              err_run_q <= err_run_d[3:0];
              if (err_run_d == 5'(ERR_LIMIT)) state_q <= S_FAULT;
            end
          end
        end
        S_FAULT: begin
          // Absorbing: only Reset leaves this state.
        end
        default: state_q <= S_UNSYNC;
      endcase
    end
  end

  assign CmdValid    = cmd_valid_q;
  assign w1          = code_q[1];
  assign w0          = code_q[0];
  assign Illegal     = illegal_q;
  assign DecodeCount = dcount_q;
  assign Locked      = (state_q == S_TRACK);
  assign Fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_fsm_counter_cmd_decoder.sv
// Randomized scoreboard bench for fsm_counter_cmd_decoder; honours RESET_INFER_EN when defined.
module tb_fsm_counter_cmd_decoder;

  localparam int WIDTH     = 4;
  localparam int ERR_LIMIT = 3;
  localparam int MASK      = (1 << WIDTH) - 1;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             Sample;
  logic [WIDTH-1:0] Count;
  logic             CmdValid, w1, w0, Locked, Illegal, Fault;
  logic [7:0]       DecodeCount;
  logic             reset_seen_w;

  fsm_counter_cmd_decoder #(.WIDTH(WIDTH), .ERR_LIMIT(ERR_LIMIT)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Sample      (Sample),
    .Count       (Count),
    .CmdValid    (CmdValid),
    .w1          (w1),
    .w0          (w0),
    .Locked      (Locked),
    .Illegal     (Illegal),
    .Fault       (Fault),
    .DecodeCount (DecodeCount)
`ifdef RESET_INFER_EN
    ,
    .ResetSeen   (reset_seen_w)
`endif
  );

`ifndef RESET_INFER_EN
  assign reset_seen_w = 1'b0;
`endif

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       cmd_valid;
    logic [1:0] code;
    logic       illegal;
    logic       reset_seen;
    logic       locked;
    logic       fault;
    logic [7:0] dcount;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: what the counter-watcher should conclude, in plain integers.
  bit m_sync, m_fault;
  int m_prev, m_err, m_dcount, m_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_fault = 0; m_prev = 0; m_err = 0; m_dcount = 0; m_code = 0;
  endtask

  task automatic model_sample(input int c);
    obs_t e;
    int   d;
    e = '0;
    if (m_fault) return;
    if (!m_sync) begin
      m_sync = 1;
      m_prev = c;
      return;
    end
    d      = (c - m_prev) & MASK;
    m_prev = c;
    if (d == 0 || d == 1 || d == 2 || d == MASK) begin
      m_code = (d == MASK) ? 3 : d;
      m_err  = 0;
      if (m_dcount < 255) m_dcount++;
      e.cmd_valid = 1'b1;
    end
`ifdef RESET_INFER_EN
    else if (c == 0) begin
      m_err        = 0;
      e.reset_seen = 1'b1;
    end
`endif
    else begin
      m_err++;
      e.illegal = 1'b1;
      if (m_err == ERR_LIMIT) m_fault = 1;
    end
    e.code   = 2'(m_code);
    e.locked = !m_fault;
    e.fault  = m_fault;
    e.dcount = 8'(m_dcount);
    exp_q.push_back(e);
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after the rising edge.
  task automatic cycle(input logic rst, input logic smp, input int c);
    Reset  = rst;
    Sample = smp;
    Count  = WIDTH'(c);
    if (rst) model_reset();
    else if (smp) model_sample(c & MASK);
    @(posedge Clock);
    #1;
  endtask

  task automatic samp(input int c);
    cycle(1'b0, 1'b1, c);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, int'($urandom));
  endtask

  task automatic check_state(input string tag);
    check({tag, "_locked"}, 32'(Locked), 32'(m_sync && !m_fault));
    check({tag, "_fault"},  32'(Fault),  32'(m_fault));
    check({tag, "_dcount"}, 32'(DecodeCount), 32'(m_dcount));
    check({tag, "_code"},   32'({w1, w0}), 32'(m_code));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({CmdValid, w1, w0, Locked, Illegal, Fault, reset_seen_w, DecodeCount}), 32'd0);
  endtask

  // Monitor: every output pulse must match the next expectation in order.
  always @(negedge Clock) begin
    obs_t a, e;
    if (CmdValid === 1'b1 || Illegal === 1'b1 || reset_seen_w === 1'b1) begin
      a.cmd_valid  = CmdValid;
      a.code       = {w1, w0};
      a.illegal    = Illegal;
      a.reset_seen = reset_seen_w;
      a.locked     = Locked;
      a.fault      = Fault;
      a.dcount     = DecodeCount;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(a), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse", 32'(a), 32'(e));
      end
    end
  end

  initial begin
    int r, k, d;
    model_reset();
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 7);
    check_all_zero("reset_state");

    // First sample locks without a pulse; next one decodes 01.
    cycle(1'b0, 1'b0, 0);
    samp(5);
    check_state("first_sample");
    samp(6);
    idle();
    check_state("first_decode");

    // Wrap-around steps 10, 11, 00.
    samp(14); samp(0); samp(15); samp(15);
    idle();
    check_state("wrap");

    // Three consecutive illegal steps fault; the fourth sample is ignored.
    cycle(1'b1, 1'b1, 7);
    samp(3); samp(9); samp(4); samp(10); samp(1);
    idle();
    check_state("fault_run");

    // A legal step clears the illegal run.
    cycle(1'b1, 1'b0, 0);
    samp(3); samp(9); samp(10); samp(5); samp(12);
    idle();
    check_state("err_cleared");

    // Reset together with Sample mid-stream: the sample must not be captured.
    samp(2); samp(3);
    cycle(1'b1, 1'b1, 8);
    check_all_zero("reset_with_sample");
    samp(9); samp(10);
    idle();
    check_state("after_reset");

    // Step to zero from 9: inferred counter reset when enabled, ordinary illegal otherwise.
    cycle(1'b1, 1'b0, 0);
    samp(8); samp(9); samp(0); samp(1);
    idle();
    check_state("zero_step");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if ((m_fault && r < 30) || r >= 96) begin
        cycle(1'b1, 1'(r & 1), int'($urandom));
      end else if (r < 10) begin
        idle();
      end else if (r < 20) begin
        d = $urandom_range(3, MASK - 1);
        samp((m_prev + d) & MASK);
      end else begin
        k = $urandom_range(0, 3);
        d = (k == 3) ? MASK : k;
        samp((m_prev + d) & MASK);
      end
    end
    idle();
    check_state("random");

    // Long legal run to push DecodeCount into saturation.
    cycle(1'b1, 1'b0, 0);
    samp(int'($urandom) & MASK);
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 3);
      d = (k == 3) ? MASK : k;
      samp((m_prev + d) & MASK);
    end
    idle();
    check_state("saturate");

    repeat (3) idle();
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
